// File: rtl/int_ctrl.sv
// int_ctrl: interrupt sequencer feeding the execute stage's single-bit interrupt input.
// Latches and masks NUM_SRC request lines, grants the lowest-index enabled pending
// source with a one-cycle int_in pulse when the pipeline can accept it, then blocks
// further grants until the handler returns (int_ret).
// Optional feature: define INT_CTRL_LEVEL_EN for level-sensitive sources; the default
// build uses rising-edge detection.
module int_ctrl #(
  parameter int unsigned NUM_SRC    = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0100,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               accept_ok,
  input  logic               int_ret,
  output logic               int_in,
  output logic [15:0]        int_vec,
  output logic [2:0]         int_src,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] req_set;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant_clr;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         pick;
  logic               grant;

`ifdef INT_CTRL_LEVEL_EN
  // Level mode: a high line requests every cycle it is asserted.
  assign req_set = irq;
`else
  logic [NUM_SRC-1:0] irq_q;

  // Previous irq sample for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq;
    end
  end

  assign req_set = irq & ~irq_q;
`endif

  assign eligible = pending_q & mask_q;
  assign grant    = (state_q == StReq) && accept_ok;

  // Priority pick: lowest enabled pending index wins.
  always_comb begin
    pick = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        pick = 3'(i);
      end
    end
  end

  // Pending update: grant clears the latched source, a new request in the same cycle wins.
  always_comb begin
    grant_clr = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      grant_clr[i] = grant && (sel_q == 3'(i));
    end
    pending_d = (pending_q & ~grant_clr) | req_set;
  end

  // sel only loads on IDLE->REQ so it stays frozen through REQ and SERVICE.
  always_comb begin
    sel_d = sel_q;
    if ((state_q == StIdle) && (|eligible)) begin
      sel_d = pick;
    end
  end

  // Pending, mask and selected-source registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
      sel_q     <= '0;
    end else begin
      pending_q <= pending_d;
      sel_q     <= sel_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; no nesting, so SERVICE only leaves on int_ret.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (|eligible) state_d = StReq;
      StReq:     if (accept_ok) state_d = StService;
      StService: if (int_ret) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; int_in is combinational on accept_ok in REQ.
  always_comb begin
    int_in     = 1'b0;
    int_vec    = 16'h0000;
    int_src    = 3'd0;
    in_service = 1'b0;
    unique case (state_q)
      StReq: begin
        int_in  = accept_ok;
        int_vec = VEC_BASE + ({13'b0, sel_q} * VEC_STRIDE);
        int_src = sel_q;
      end
      StService: begin
        int_src    = sel_q;
        in_service = 1'b1;
      end
      default: ;
    endcase
  end

  assign pending = pending_q;
  assign mask    = mask_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: reset check, a vector table for the basic grant,
// hand-written multi-cycle sequences, then randomized traffic against a reference model.
module tb_int_ctrl;

  localparam int NUM = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NUM-1:0] irq = '0;
  logic           mask_we = 1'b0;
  logic [NUM-1:0] mask_wdata = '0;
  logic           accept_ok = 1'b0;
  logic           int_ret = 1'b0;
  logic           int_in;
  logic [15:0]    int_vec;
  logic [2:0]     int_src;
  logic           in_service;
  logic [NUM-1:0] pending;
  logic [NUM-1:0] mask;

  int_ctrl #(
    .NUM_SRC   (NUM),
    .VEC_BASE  (16'h0100),
    .VEC_STRIDE(16'h0010)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .accept_ok (accept_ok),
    .int_ret   (int_ret),
    .int_in    (int_in),
    .int_vec   (int_vec),
    .int_src   (int_src),
    .in_service(in_service),
    .pending   (pending),
    .mask      (mask)
  );

  always #5 clk = ~clk;

  // Staged stimulus, applied to the DUT at the next falling edge.
  logic [NUM-1:0] s_irq = '0;
  logic           s_mwe = 1'b0;
  logic [NUM-1:0] s_mwd = '0;
  logic           s_acc = 1'b0;
  logic           s_ret = 1'b0;
  logic           s_rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which source is waiting for acceptance, which is being serviced.
  bit [NUM-1:0] m_pend, m_mask, m_prev;
  int           m_req = -1;
  int           m_svc = -1;
  bit           m_ok  = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int exp_vec, exp_src;
    exp_vec = (m_req >= 0) ? 256 + 16 * m_req : 0;
    exp_src = (m_req >= 0) ? m_req : ((m_svc >= 0) ? m_svc : 0);
    check("m_int_in", 32'(int_in), 32'((m_req >= 0) && s_acc));
    check("m_int_vec", 32'(int_vec), exp_vec);
    check("m_int_src", 32'(int_src), exp_src);
    check("m_in_service", 32'(in_service), 32'(m_svc >= 0));
    check("m_pending", 32'(pending), 32'(m_pend));
    check("m_mask", 32'(mask), 32'(m_mask));
  endtask

  task automatic model_step();
    bit [NUM-1:0] newreq, np;
    int p;
    if (s_rst) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_req = -1; m_svc = -1; m_ok = 1'b1;
      return;
    end
`ifdef INT_CTRL_LEVEL_EN
    newreq = s_irq;
`else
    newreq = s_irq & ~m_prev;
`endif
    np = m_pend;
    if (m_req >= 0 && s_acc) np[m_req] = 1'b0;
    np = np | newreq;
    if (m_req >= 0) begin
      if (s_acc) begin
        m_svc = m_req;
        m_req = -1;
      end
    end else if (m_svc >= 0) begin
      if (s_ret) m_svc = -1;
    end else begin
      p = -1;
      for (int i = NUM - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) p = i;
      m_req = p;
    end
    if (s_mwe) m_mask = s_mwd;
    m_prev = s_irq;
    m_pend = np;
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, advance the model.
  task automatic apply();
    @(negedge clk);
    irq = s_irq; mask_we = s_mwe; mask_wdata = s_mwd;
    accept_ok = s_acc; int_ret = s_ret; rst = s_rst;
    #1;
    if (m_ok) model_check();
    model_step();
  endtask

  task automatic wait_grant(input int max, input string name, output logic [15:0] vec);
    bit got;
    got = 1'b0;
    vec = '0;
    for (int k = 0; k < max && !got; k++) begin
      apply();
      if (int_in) begin
        got = 1'b1;
        vec = int_vec;
      end
    end
    check({name, "_seen"}, 32'(got), 1);
  endtask

  task automatic drain(input int n);
    s_irq = '0; s_acc = 1'b1; s_ret = 1'b1;
    repeat (n) apply();
    s_acc = 1'b0; s_ret = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  irq;
    logic        mwe;
    logic [3:0]  mwd;
    logic        acc;
    logic        ret;
    logic        e_int;
    logic [15:0] e_vec;
    logic [2:0]  e_src;
    logic        e_svc;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [15:0] v;
    int gap, grants;
    bit seen;

    tbl[0] = '{4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'h0};
    tbl[1] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'h0};
    tbl[2] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'h4};
    tbl[3] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h0120, 3'd2, 1'b0, 4'h4};
    tbl[4] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b1, 4'h0};
    tbl[5] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd2, 1'b1, 4'h0};
    tbl[6] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'h0};

    // Reset; the second cycle compares the post-reset state.
    s_rst = 1'b1;
    apply();
    apply();
    check("rst_pending", 32'(pending), 0);
    check("rst_mask", 32'(mask), 0);
    s_rst = 1'b0;

    // Single pulse on irq[2] with the pipeline ready.
    for (int r = 0; r < 7; r++) begin
      s_irq = tbl[r].irq; s_mwe = tbl[r].mwe; s_mwd = tbl[r].mwd;
      s_acc = tbl[r].acc; s_ret = tbl[r].ret;
      apply();
      check($sformatf("tbl%0d_int_in", r), 32'(int_in), 32'(tbl[r].e_int));
      check($sformatf("tbl%0d_int_vec", r), 32'(int_vec), 32'(tbl[r].e_vec));
      check($sformatf("tbl%0d_int_src", r), 32'(int_src), 32'(tbl[r].e_src));
      check($sformatf("tbl%0d_in_service", r), 32'(in_service), 32'(tbl[r].e_svc));
      check($sformatf("tbl%0d_pending", r), 32'(pending), 32'(tbl[r].e_pend));
    end
    s_irq = '0; s_mwe = 1'b0; s_acc = 1'b0; s_ret = 1'b0;

    // Simultaneous sources 3 and 1: priority, then one IDLE cycle before the next grant.
    s_irq = 4'b1010;
    apply();
    s_irq = '0; s_acc = 1'b1;
    wait_grant(6, "prio_first", v);
    check("prio_first_vec", 32'(v), 32'h0110);
    apply();
    s_ret = 1'b1;
    apply();
    s_ret = 1'b0;
    gap = 0; seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      apply();
      gap++;
      if (int_in) seen = 1'b1;
    end
    check("prio_second_gap", gap, 2);
    check("prio_second_vec", 32'(int_vec), 32'h0130);
    apply();
    s_ret = 1'b1;
    apply();
    s_ret = 1'b0;

    // Stall in REQ; a higher-priority arrival must not steal the latched source.
    s_acc = 1'b0; s_irq = 4'b0100;
    apply();
    s_irq = '0;
    apply();
    for (int k = 0; k < 5; k++) begin
      s_irq = (k == 2) ? 4'b0001 : 4'b0000;
      apply();
      check("stall_int_in", 32'(int_in), 0);
      check("stall_src", 32'(int_src), 2);
    end
    s_irq = '0; s_acc = 1'b1;
    apply();
    check("stall_release_int_in", 32'(int_in), 1);
    check("stall_release_vec", 32'(int_vec), 32'h0120);
    apply();
    check("stall_single_pulse", 32'(int_in), 0);
    check("stall_in_service", 32'(in_service), 1);
    drain(8);

    // Masked source stays pending, then fires once enabled.
    s_mwe = 1'b1; s_mwd = 4'b0000;
    apply();
    s_mwe = 1'b0; s_irq = 4'b0001;
    apply();
    s_irq = '0; s_acc = 1'b1;
    apply();
    check("masked_pending", 32'(pending), 32'h1);
    repeat (3) begin
      apply();
      check("masked_no_int", 32'(int_in), 0);
    end
    s_mwe = 1'b1; s_mwd = 4'b0001;
    apply();
    s_mwe = 1'b0;
    wait_grant(3, "unmask", v);
    check("unmask_vec", 32'(v), 32'h0100);

    // Re-request of source 0 while it is being serviced.
    s_irq = 4'b0001;
    apply();
    check("resvc_in_service", 32'(in_service), 1);
    s_irq = '0;
    apply();
    check("resvc_pending", 32'(pending), 32'h1);
    repeat (3) begin
      apply();
      check("resvc_no_int", 32'(int_in), 0);
    end
    s_ret = 1'b1;
    apply();
    s_ret = 1'b0;
    wait_grant(4, "resvc_second", v);
    check("resvc_second_vec", 32'(v), 32'h0100);
    apply();

    // Reset in the middle of a handler with other sources pending.
    s_irq = 4'b0110;
    apply();
    s_irq = '0;
    apply();
    check("midrst_pending_before", 32'(pending), 32'h6);
    check("midrst_svc_before", 32'(in_service), 1);
    s_rst = 1'b1;
    apply();
    s_rst = 1'b0;
    apply();
    check("midrst_pending", 32'(pending), 0);
    check("midrst_mask", 32'(mask), 0);
    check("midrst_in_service", 32'(in_service), 0);
    check("midrst_int_src", 32'(int_src), 0);

    // Held-high line: one grant in edge mode, repeated grants in level mode.
    s_mwe = 1'b1; s_mwd = 4'hF;
    apply();
    s_mwe = 1'b0; s_irq = 4'b1000; s_acc = 1'b1; s_ret = 1'b1;
    grants = 0;
    repeat (20) begin
      apply();
      if (int_in) grants++;
    end
    s_irq = '0;
    repeat (4) begin
      apply();
      if (int_in) grants++;
    end
`ifdef INT_CTRL_LEVEL_EN
    check("held_regrants", 32'(grants >= 3), 1);
`else
    check("held_one_grant", grants, 1);
`endif
    drain(6);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      s_irq = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      s_mwe = ($urandom_range(0, 15) == 0);
      s_mwd = 4'($urandom);
      s_acc = ($urandom_range(0, 2) != 0);
      s_ret = ($urandom_range(0, 3) == 0);
      s_rst = ($urandom_range(0, 199) == 0);
      apply();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
